add_exec_pipe: RTL and testbench

Parametrised, pipelined integer add/sub/logic execution unit for the Tomasulo core. It accepts one ready-operand instruction per cycle from the add reservation station via a valid/ready handshake. The result goes through a LAT-stage pipeline into an in-order output buffer, then to the CDB via a second valid/ready handshake. The unit holds no global state: tag wake-up, ROB and register-bank writes are done by the CDB consumer using the broadcast rob/rd/rs tags.

---
 rtl/add_exec_pipe.sv | 191 +++++++++++++++++++
 tb/tb_add_exec_pipe.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/add_exec_pipe.sv
// Pipelined add/sub/logic execution unit with credit-controlled in-order output buffer to the CDB.
// Optional signed saturation of add/sub when ADD_EXEC_SAT_EN is defined.
module add_exec_pipe #(
    parameter int DATA_W    = 8,
    parameter int ROB_W     = 3,
    parameter int RS_W      = 3,
    parameter int REG_W     = 4,
    parameter int LAT       = 2,
    parameter int OUT_DEPTH = 3
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_flush,
    input  logic              i_issue_valid,
    output logic              o_issue_ready,
    input  logic [3:0]        i_issue_func,
    input  logic [DATA_W-1:0] i_issue_rs1,
    input  logic [DATA_W-1:0] i_issue_rs2,
    input  logic [ROB_W-1:0]  i_issue_rob,
    input  logic [RS_W-1:0]   i_issue_rs_idx,
    input  logic [REG_W-1:0]  i_issue_rd,
    output logic              o_cdb_valid,
    input  logic              i_cdb_ready,
    output logic [DATA_W-1:0] o_cdb_data,
    output logic              o_cdb_carry,
    output logic              o_cdb_err,
    output logic [ROB_W-1:0]  o_cdb_rob,
    output logic [REG_W-1:0]  o_cdb_rd,
    output logic [RS_W-1:0]   o_cdb_rs_idx,
    output logic              o_busy
);

    localparam int PW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam int CW = $clog2(OUT_DEPTH + 1);
    localparam logic [DATA_W-1:0] MAX_POS = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] MIN_NEG = {1'b1, {(DATA_W-1){1'b0}}};

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              carry;
        logic              err;
        logic [ROB_W-1:0]  rob;
        logic [REG_W-1:0]  rd;
        logic [RS_W-1:0]   rs_idx;
    } entry_t;

    logic          w_fire;
    logic          w_pop;
    logic          w_push;
    entry_t        w_new;
    entry_t        w_push_ent;
    entry_t        w_head;
    logic [DATA_W:0] w_sum;
    logic [DATA_W:0] w_diff;

    entry_t        r_mem [OUT_DEPTH];
    logic [PW-1:0] r_wr;
    logic [PW-1:0] r_rd;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] r_occ;

    assign w_fire = i_issue_valid && o_issue_ready;
    assign w_pop  = o_cdb_valid && i_cdb_ready;
    assign w_sum  = {1'b0, i_issue_rs1} + {1'b0, i_issue_rs2};
    // MSB of the widened difference is the unsigned borrow
    assign w_diff = {1'b0, i_issue_rs1} - {1'b0, i_issue_rs2};

    always_comb begin
        w_new        = '0;
        w_new.rob    = i_issue_rob;
        w_new.rd     = i_issue_rd;
        w_new.rs_idx = i_issue_rs_idx;
        case (i_issue_func)
            4'b0000: begin
`ifdef ADD_EXEC_SAT_EN
                if (!i_issue_rs1[DATA_W-1] && !i_issue_rs2[DATA_W-1] && w_sum[DATA_W-1]) begin
                    w_new.data  = MAX_POS;
                    w_new.carry = 1'b1;
                end else if (i_issue_rs1[DATA_W-1] && i_issue_rs2[DATA_W-1] && !w_sum[DATA_W-1]) begin
                    w_new.data  = MIN_NEG;
                    w_new.carry = 1'b1;
                end else begin
                    w_new.data  = w_sum[DATA_W-1:0];
                end
`else
                w_new.data  = w_sum[DATA_W-1:0];
                w_new.carry = w_sum[DATA_W];
`endif
            end
            4'b0001: begin
`ifdef ADD_EXEC_SAT_EN
                if (!i_issue_rs1[DATA_W-1] && i_issue_rs2[DATA_W-1] && w_diff[DATA_W-1]) begin
                    w_new.data  = MAX_POS;
                    w_new.carry = 1'b1;
                end else if (i_issue_rs1[DATA_W-1] && !i_issue_rs2[DATA_W-1] && !w_diff[DATA_W-1]) begin
                    w_new.data  = MIN_NEG;
                    w_new.carry = 1'b1;
                end else begin
                    w_new.data  = w_diff[DATA_W-1:0];
                end
`else
                w_new.data  = w_diff[DATA_W-1:0];
                w_new.carry = w_diff[DATA_W];
`endif
            end
            4'b0010: w_new.data = i_issue_rs1 & i_issue_rs2;
            4'b0011: w_new.data = i_issue_rs1 | i_issue_rs2;
            4'b0100: w_new.data = i_issue_rs1 ^ i_issue_rs2;
            4'b0101: w_new.data = {{(DATA_W-1){1'b0}},
                                   ($signed(i_issue_rs1) < $signed(i_issue_rs2))};
            default: w_new.err  = 1'b1;
        endcase
    end

    // The buffer write is the last of the LAT stages, so only LAT-1 registers sit in front of it
    generate
        if (LAT == 1) begin : g_no_stage
            assign w_push     = w_fire;
            assign w_push_ent = w_new;
        end else begin : g_stages
            entry_t         r_stg   [LAT-1];
            logic [LAT-2:0] r_stg_v;

            always_ff @(posedge i_clk) begin
                if (i_rst || i_flush) begin
                    r_stg_v <= '0;
                end else begin
                    r_stg_v[0] <= w_fire;
                    for (int k = 1; k < LAT-1; k++) begin
                        r_stg_v[k] <= r_stg_v[k-1];
                    end
                end
                r_stg[0] <= w_new;
                for (int k = 1; k < LAT-1; k++) begin
                    r_stg[k] <= r_stg[k-1];
                end
            end

            assign w_push     = r_stg_v[LAT-2];
            assign w_push_ent = r_stg[LAT-2];
        end
    endgenerate

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
            r_occ <= '0;
            for (int i = 0; i < OUT_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_flush) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
            r_occ <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr] <= w_push_ent;
                r_wr <= (r_wr == PW'(OUT_DEPTH-1)) ? '0 : r_wr + PW'(1);
            end
            if (w_pop) begin
                r_rd <= (r_rd == PW'(OUT_DEPTH-1)) ? '0 : r_rd + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + CW'(1);
                2'b01:   r_cnt <= r_cnt - CW'(1);
                default: r_cnt <= r_cnt;
            endcase
            // Credit counts everything from issue until it leaves on the CDB
            case ({w_fire, w_pop})
                2'b10:   r_occ <= r_occ + CW'(1);
                2'b01:   r_occ <= r_occ - CW'(1);
                default: r_occ <= r_occ;
            endcase
        end
    end

    assign w_head        = r_mem[r_rd];
    assign o_cdb_valid   = (r_cnt != '0);
    assign o_cdb_data    = w_head.data;
    assign o_cdb_carry   = w_head.carry;
    assign o_cdb_err     = w_head.err;
    assign o_cdb_rob     = w_head.rob;
    assign o_cdb_rd      = w_head.rd;
    assign o_cdb_rs_idx  = w_head.rs_idx;
    assign o_issue_ready = (r_occ < CW'(OUT_DEPTH));
    assign o_busy        = (r_occ != '0);

endmodule

// File: tb/tb_add_exec_pipe.sv
// Randomized self-checking bench for add_exec_pipe: a queue-based scoreboard models
// credit, latency, ordering and arithmetic from the functional rules.
module tb_add_exec_pipe;

    localparam int DATA_W    = 8;
    localparam int ROB_W     = 3;
    localparam int RS_W      = 3;
    localparam int REG_W     = 4;
    localparam int LAT       = 2;
    localparam int OUT_DEPTH = 3;

    logic              i_clk = 1'b0;
    logic              i_rst;
    logic              i_flush;
    logic              i_issue_valid;
    logic              o_issue_ready;
    logic [3:0]        i_issue_func;
    logic [DATA_W-1:0] i_issue_rs1;
    logic [DATA_W-1:0] i_issue_rs2;
    logic [ROB_W-1:0]  i_issue_rob;
    logic [RS_W-1:0]   i_issue_rs_idx;
    logic [REG_W-1:0]  i_issue_rd;
    logic              o_cdb_valid;
    logic              i_cdb_ready;
    logic [DATA_W-1:0] o_cdb_data;
    logic              o_cdb_carry;
    logic              o_cdb_err;
    logic [ROB_W-1:0]  o_cdb_rob;
    logic [REG_W-1:0]  o_cdb_rd;
    logic [RS_W-1:0]   o_cdb_rs_idx;
    logic              o_busy;

    always #5 i_clk = ~i_clk;

    add_exec_pipe #(
        .DATA_W(DATA_W), .ROB_W(ROB_W), .RS_W(RS_W), .REG_W(REG_W),
        .LAT(LAT), .OUT_DEPTH(OUT_DEPTH)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_flush(i_flush),
        .i_issue_valid(i_issue_valid), .o_issue_ready(o_issue_ready),
        .i_issue_func(i_issue_func), .i_issue_rs1(i_issue_rs1), .i_issue_rs2(i_issue_rs2),
        .i_issue_rob(i_issue_rob), .i_issue_rs_idx(i_issue_rs_idx), .i_issue_rd(i_issue_rd),
        .o_cdb_valid(o_cdb_valid), .i_cdb_ready(i_cdb_ready),
        .o_cdb_data(o_cdb_data), .o_cdb_carry(o_cdb_carry), .o_cdb_err(o_cdb_err),
        .o_cdb_rob(o_cdb_rob), .o_cdb_rd(o_cdb_rd), .o_cdb_rs_idx(o_cdb_rs_idx),
        .o_busy(o_busy)
    );

    typedef struct {
        logic [7:0] data;
        logic       carry;
        logic       err;
        logic [2:0] rob;
        logic [3:0] rd;
        logic [2:0] rs;
        int         vis;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0;
    int   n_err = 0;
    int   cyc   = 0;

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc);
        end
    endtask

    function automatic exp_t model(input logic [3:0] f, input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        int   sa;
        int   sb;
        int   r;
        e.data = 8'h00; e.carry = 1'b0; e.err = 1'b0;
        e.rob = '0; e.rd = '0; e.rs = '0; e.vis = 0;
        sa = (a >= 8'd128) ? int'(a) - 256 : int'(a);
        sb = (b >= 8'd128) ? int'(b) - 256 : int'(b);
        case (f)
            4'd0, 4'd1: begin
`ifdef ADD_EXEC_SAT_EN
                r = (f == 4'd0) ? sa + sb : sa - sb;
                if (r > 127) begin
                    e.data = 8'h7F; e.carry = 1'b1;
                end else if (r < -128) begin
                    e.data = 8'h80; e.carry = 1'b1;
                end else begin
                    e.data = r[7:0];
                end
`else
                if (f == 4'd0) begin
                    r = int'(a) + int'(b);
                    e.carry = (r > 255);
                end else begin
                    r = int'(a) - int'(b);
                    e.carry = (a < b);
                end
                e.data = r[7:0];
`endif
            end
            4'd2: e.data = a & b;
            4'd3: e.data = a | b;
            4'd4: e.data = a ^ b;
            4'd5: e.data = (sa < sb) ? 8'd1 : 8'd0;
            default: e.err = 1'b1;
        endcase
        return e;
    endfunction

    task automatic check_reset_state();
        chk("rst_cdb_valid", o_cdb_valid, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_issue_ready", o_issue_ready, 1);
        chk("rst_cdb_data", o_cdb_data, 0);
        chk("rst_cdb_carry", o_cdb_carry, 0);
        chk("rst_cdb_err", o_cdb_err, 0);
        chk("rst_cdb_rob", o_cdb_rob, 0);
        chk("rst_cdb_rd", o_cdb_rd, 0);
        chk("rst_cdb_rs_idx", o_cdb_rs_idx, 0);
    endtask

    // One clock: check outputs against the scoreboard, drive inputs, advance the model
    task automatic step(input logic v, input logic [3:0] f, input logic [7:0] a, input logic [7:0] b,
                        input logic [2:0] rob, input logic [3:0] rd, input logic [2:0] rs,
                        input logic rdy, input logic fl, output logic acc);
        logic exp_v;
        logic exp_rdy;
        exp_t e;
        @(negedge i_clk);
        exp_v   = 1'b0;
        if (q.size() > 0) exp_v = (q[0].vis <= cyc);
        exp_rdy = (q.size() < OUT_DEPTH);
        chk("cdb_valid", o_cdb_valid, exp_v);
        chk("issue_ready", o_issue_ready, exp_rdy);
        chk("busy", o_busy, q.size() != 0);
        if (exp_v) begin
            chk("cdb_data", o_cdb_data, q[0].data);
            chk("cdb_carry", o_cdb_carry, q[0].carry);
            chk("cdb_err", o_cdb_err, q[0].err);
            chk("cdb_rob", o_cdb_rob, q[0].rob);
            chk("cdb_rd", o_cdb_rd, q[0].rd);
            chk("cdb_rs_idx", o_cdb_rs_idx, q[0].rs);
        end
        i_issue_valid  = v;
        i_issue_func   = f;
        i_issue_rs1    = a;
        i_issue_rs2    = b;
        i_issue_rob    = rob;
        i_issue_rd     = rd;
        i_issue_rs_idx = rs;
        i_cdb_ready    = rdy;
        i_flush        = fl;
        acc = 1'b0;
        if (fl) begin
            q.delete();
        end else begin
            if (exp_v && rdy) void'(q.pop_front());
            if (v && exp_rdy) begin
                e = model(f, a, b);
                e.rob = rob; e.rd = rd; e.rs = rs;
                e.vis = cyc + LAT;
                q.push_back(e);
                acc = 1'b1;
            end
        end
        @(posedge i_clk);
    endtask

    task automatic idle(input int n, input logic rdy);
        logic acc;
        for (int i = 0; i < n; i++) step(1'b0, 4'd0, 8'd0, 8'd0, 3'd0, 4'd0, 3'd0, rdy, 1'b0, acc);
    endtask

    logic acc;
    logic [7:0] ra;
    logic [7:0] rb;

    initial begin
        i_rst = 1'b1; i_flush = 1'b0; i_issue_valid = 1'b0; i_issue_func = '0;
        i_issue_rs1 = '0; i_issue_rs2 = '0; i_issue_rob = '0; i_issue_rd = '0;
        i_issue_rs_idx = '0; i_cdb_ready = 1'b0;
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b0;
        check_reset_state();

        // single add, then back-to-back mix
        step(1'b1, 4'd0, 8'h05, 8'h03, 3'd3, 4'd4, 3'd1, 1'b1, 1'b0, acc);
        idle(4, 1'b1);
        step(1'b1, 4'd1, 8'h03, 8'h05, 3'd1, 4'd1, 3'd1, 1'b1, 1'b0, acc);
        step(1'b1, 4'd0, 8'hFF, 8'h01, 3'd2, 4'd2, 3'd2, 1'b1, 1'b0, acc);
        step(1'b1, 4'd5, 8'h80, 8'h01, 3'd3, 4'd3, 3'd3, 1'b1, 1'b0, acc);
        idle(4, 1'b1);

        // credit limit with a stalled CDB
        for (int i = 0; i < 6; i++)
            step(1'b1, 4'd0, 8'(i), 8'h10, 3'(i), 4'(i), 3'(i), 1'b0, 1'b0, acc);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 4'd2, 8'hF0, 8'h3C, 3'd7, 4'd7, 3'd7, 1'b1, 1'b0, acc);
            if (acc) break;
        end
        idle(6, 1'b1);

        // flush with work in the pipe, then flush colliding with an issue and a pop
        step(1'b1, 4'd0, 8'h11, 8'h22, 3'd1, 4'd1, 3'd1, 1'b1, 1'b0, acc);
        step(1'b1, 4'd1, 8'h33, 8'h44, 3'd2, 4'd2, 3'd2, 1'b1, 1'b1, acc);
        idle(4, 1'b1);
        step(1'b1, 4'd3, 8'h0F, 8'hA0, 3'd4, 4'd4, 3'd4, 1'b1, 1'b0, acc);
        step(1'b1, 4'd4, 8'hFF, 8'h0F, 3'd5, 4'd5, 3'd5, 1'b1, 1'b0, acc);
        step(1'b1, 4'd0, 8'h01, 8'h01, 3'd6, 4'd6, 3'd6, 1'b1, 1'b1, acc);
        idle(4, 1'b1);

        // illegal func and saturation corners
        step(1'b1, 4'hF, 8'h12, 8'h34, 3'd2, 4'd9, 3'd5, 1'b1, 1'b0, acc);
        step(1'b1, 4'd0, 8'h7F, 8'h01, 3'd3, 4'd3, 3'd3, 1'b1, 1'b0, acc);
        step(1'b1, 4'd1, 8'h80, 8'h01, 3'd4, 4'd4, 3'd4, 1'b1, 1'b0, acc);
        step(1'b1, 4'd6, 8'h55, 8'hAA, 3'd5, 4'd5, 3'd5, 1'b1, 1'b0, acc);
        idle(5, 1'b1);

        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 3))
                0: ra = 8'h80;
                1: ra = 8'h7F;
                default: ra = 8'($urandom);
            endcase
            rb = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
            step($urandom_range(0, 3) != 0,
                 ($urandom_range(0, 15) == 0) ? 4'($urandom) : 4'($urandom_range(0, 5)),
                 ra, rb, 3'($urandom), 4'($urandom), 3'($urandom),
                 (i % 200 < 100) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 63) == 0), acc);
        end

        // mid-operation reset
        step(1'b1, 4'd0, 8'h21, 8'h43, 3'd1, 4'd2, 3'd3, 1'b0, 1'b0, acc);
        step(1'b1, 4'd1, 8'h99, 8'h11, 3'd4, 4'd5, 3'd6, 1'b0, 1'b0, acc);
        step(1'b1, 4'd2, 8'hC3, 8'h5A, 3'd7, 4'd7, 3'd7, 1'b0, 1'b0, acc);
        @(negedge i_clk);
        i_rst = 1'b1;
        i_issue_valid = 1'b0;
        q.delete();
        @(posedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b0;
        check_reset_state();
        step(1'b1, 4'd0, 8'h05, 8'h03, 3'd3, 4'd4, 3'd1, 1'b1, 1'b0, acc);
        idle(4, 1'b1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
